// File: rtl/uart_pkg.sv
// uart_pkg
// Shared types and helpers for the UART frame checker.
//   parity_e        : parity setting (none / even / odd)
//   chk_state_e     : frame-tracking FSM states
//   expected_parity : parity bit a well-formed frame should carry
package uart_pkg;

    localparam int MAX_DATA_BITS = 9;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } chk_state_e;

    // Data is zero-extended by the caller, which leaves the XOR unchanged.
    function automatic logic expected_parity(input logic [MAX_DATA_BITS-1:0] data,
                                             input parity_e mode);
        logic p;
        p = ^data;
        return (mode == PAR_ODD) ? ~p : p;
    endfunction

endpackage

// File: rtl/uart_sat_counter.sv
// uart_sat_counter
// Saturating up-counter with synchronous clear.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : count one event this cycle
//   clr        : zero the counter (wins over inc)
//   count      : current value, sticks at all-ones
module uart_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;

    // Clear has priority; increments stop once the counter is all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/uart_frame_checker.sv
// uart_frame_checker
// Monitors a UART TX line sampled on bit_tick, decodes each frame and
// reports data plus parity / stop / break errors with saturating counters.
//   clk, rst_n   : clock, asynchronous active-low reset
//   bit_tick     : one-cycle pulse per bit period, txd sampled only then
//   txd          : monitored line
//   chk_en       : checker enable; low aborts any frame in flight
//   clr_cnt      : synchronous clear of both counters
//   frame_valid  : one-cycle pulse per completed frame
//   frame_data   : last decoded word, held between frames
//   parity_err, stop_err, break_det : error flags, valid with frame_valid
//   busy         : a frame is in progress
//   frame_cnt, err_cnt : saturating frame and errored-frame counters
module uart_frame_checker
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1,
    parameter int CNT_W       = 16,
    parameter int ASSERT_EN   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 bit_tick,
    input  logic                 txd,
    input  logic                 chk_en,
    input  logic                 clr_cnt,
    output logic                 frame_valid,
    output logic [DATA_BITS-1:0] frame_data,
    output logic                 parity_err,
    output logic                 stop_err,
    output logic                 break_det,
    output logic                 busy,
    output logic [CNT_W-1:0]     frame_cnt,
    output logic [CNT_W-1:0]     err_cnt
);

    localparam logic [3:0] LAST_BIT   = 4'(DATA_BITS - 1);
    localparam logic       LAST_STOP  = 1'(STOP_BITS - 1);
    localparam logic [1:0] PMODE_BITS = 2'(PARITY_MODE);
    localparam parity_e    PMODE      = parity_e'(PMODE_BITS);

    chk_state_e             state_q, state_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic                   stop_cnt_q, stop_cnt_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_bit_q, par_bit_d;
    logic                   par_pend_q, par_pend_d;
    logic                   stop_pend_q, stop_pend_d;
    logic                   brk_pend_q, brk_pend_d;

    logic                   done;
    logic                   par_fin, stop_fin, brk_fin;
    logic                   brk_now;
    logic                   err_inc;
    logic [MAX_DATA_BITS-1:0] data_ext;

    logic                   frame_valid_q, parity_err_q, stop_err_q, break_det_q;
    logic [DATA_BITS-1:0]   frame_data_q;

    // Next-state logic. Nothing advances without bit_tick, and a low chk_en
    // drops straight back to IDLE discarding the partial frame.
    // Final flags are resolved on the last stop sample so the reporting
    // registers and the counters can all update on that same edge.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        stop_cnt_d  = stop_cnt_q;
        shift_d     = shift_q;
        par_bit_d   = par_bit_q;
        par_pend_d  = par_pend_q;
        stop_pend_d = stop_pend_q;
        brk_pend_d  = brk_pend_q;
        done        = 1'b0;
        par_fin     = 1'b0;
        stop_fin    = 1'b0;
        brk_fin     = 1'b0;

        data_ext                = '0;
        data_ext[DATA_BITS-1:0] = shift_q;
        // A break needs every data bit, any parity bit and the first stop low.
        brk_now = (shift_q == '0) && !par_bit_q && !txd;

        if (!chk_en) begin
            state_d     = IDLE;
            par_pend_d  = 1'b0;
            stop_pend_d = 1'b0;
            brk_pend_d  = 1'b0;
        end else if (bit_tick) begin
            case (state_q)
                IDLE: begin
                    if (!txd) begin
                        state_d     = DATA;
                        bit_cnt_d   = '0;
                        stop_cnt_d  = 1'b0;
                        par_bit_d   = 1'b0;
                        par_pend_d  = 1'b0;
                        stop_pend_d = 1'b0;
                        brk_pend_d  = 1'b0;
                    end
                end
                DATA: begin
                    for (int i = 0; i < DATA_BITS; i++) begin
                        if (bit_cnt_q == 4'(i)) begin
                            shift_d[i] = txd;
                        end
                    end
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = (PMODE != PAR_NONE) ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
                PARITY: begin
                    par_bit_d  = txd;
                    par_pend_d = (txd != expected_parity(data_ext, PMODE));
                    state_d    = STOP;
                end
                STOP: begin
                    if (stop_cnt_q == 1'b0) begin
                        brk_pend_d = brk_now;
                    end
                    if (!txd) begin
                        stop_pend_d = 1'b1;
                    end
                    if (stop_cnt_q == LAST_STOP) begin
                        state_d  = IDLE;
                        done     = 1'b1;
                        brk_fin  = (stop_cnt_q == 1'b0) ? brk_now : brk_pend_q;
                        // A break is reported on its own, masking the other flags.
                        stop_fin = (stop_pend_q | !txd) & !brk_fin;
                        par_fin  = par_pend_q & !brk_fin;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Frame-tracking state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            stop_cnt_q  <= 1'b0;
            shift_q     <= '0;
            par_bit_q   <= 1'b0;
            par_pend_q  <= 1'b0;
            stop_pend_q <= 1'b0;
            brk_pend_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            stop_cnt_q  <= stop_cnt_d;
            shift_q     <= shift_d;
            par_bit_q   <= par_bit_d;
            par_pend_q  <= par_pend_d;
            stop_pend_q <= stop_pend_d;
            brk_pend_q  <= brk_pend_d;
        end
    end

    // Reporting registers, independent of the FSM so a new frame can start
    // while the previous result is being presented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_valid_q <= 1'b0;
            parity_err_q  <= 1'b0;
            stop_err_q    <= 1'b0;
            break_det_q   <= 1'b0;
            frame_data_q  <= '0;
        end else begin
            frame_valid_q <= done;
            parity_err_q  <= par_fin;
            stop_err_q    <= stop_fin;
            break_det_q   <= brk_fin;
            if (done) begin
                frame_data_q <= shift_q;
            end
        end
    end

    assign err_inc = done & (par_fin | stop_fin | brk_fin);

    uart_sat_counter #(.W(CNT_W)) u_frame_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (done),
        .clr   (clr_cnt),
        .count (frame_cnt)
    );

    uart_sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (err_inc),
        .clr   (clr_cnt),
        .count (err_cnt)
    );

    assign frame_valid = frame_valid_q;
    assign frame_data  = frame_data_q;
    assign parity_err  = parity_err_q;
    assign stop_err    = stop_err_q;
    assign break_det   = break_det_q;
    assign busy        = (state_q != IDLE);

    generate
        if (ASSERT_EN != 0) begin : g_assert
            a_frame_clean: assert property (@(posedge clk) disable iff (!rst_n)
                frame_valid |-> !(parity_err || stop_err || break_det))
                else $error("uart_frame_checker: errored frame (parity=%0b stop=%0b break=%0b data=0x%0h)",
                            parity_err, stop_err, break_det, frame_data);
        end
    endgenerate

endmodule

// File: tb/tb_uart_frame_checker.sv
// Bench for uart_frame_checker. Three instances cover the configurations:
//   u0 : 8 data bits, even parity, 1 stop bit
//   u1 : 8 data bits, no parity, 2 stop bits
//   u2 : 8 data bits, no parity, 1 stop bit, 2-bit counters, assertions on
// Expected frames are queued before stimulus; a monitor pops and compares
// on every frame_valid.
module tb_uart_frame_checker;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [2:0] rstn, tick, txd, en, clr;
   logic [2:0] fv, perr, serr, brk, busy;
   logic [7:0]  fd0, fd1, fd2;
   logic [15:0] fc0, fc1, ec0, ec1;
   logic [1:0]  fc2, ec2;

   typedef struct {
      int         inst;
      logic [7:0] data;
      logic       perr;
      logic       serr;
      logic       brk;
      int         fcnt;
      int         ecnt;
   } exp_t;

   exp_t expQ[$];
   exp_t monExp;
   int   checks = 0;
   int   errors = 0;

   logic [7:0] cleanData [5] = '{8'h01, 8'h22, 8'h7E, 8'hC3, 8'hFF};
   int         cleanFc   [5] = '{1, 2, 3, 3, 3};
   logic [7:0] lastData;

   uart_frame_checker #(.DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1), .CNT_W(16), .ASSERT_EN(0)) u0 (
      .clk(clk), .rst_n(rstn[0]), .bit_tick(tick[0]), .txd(txd[0]), .chk_en(en[0]), .clr_cnt(clr[0]),
      .frame_valid(fv[0]), .frame_data(fd0), .parity_err(perr[0]), .stop_err(serr[0]),
      .break_det(brk[0]), .busy(busy[0]), .frame_cnt(fc0), .err_cnt(ec0));

   uart_frame_checker #(.DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(2), .CNT_W(16), .ASSERT_EN(0)) u1 (
      .clk(clk), .rst_n(rstn[1]), .bit_tick(tick[1]), .txd(txd[1]), .chk_en(en[1]), .clr_cnt(clr[1]),
      .frame_valid(fv[1]), .frame_data(fd1), .parity_err(perr[1]), .stop_err(serr[1]),
      .break_det(brk[1]), .busy(busy[1]), .frame_cnt(fc1), .err_cnt(ec1));

   uart_frame_checker #(.DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .CNT_W(2), .ASSERT_EN(1)) u2 (
      .clk(clk), .rst_n(rstn[2]), .bit_tick(tick[2]), .txd(txd[2]), .chk_en(en[2]), .clr_cnt(clr[2]),
      .frame_valid(fv[2]), .frame_data(fd2), .parity_err(perr[2]), .stop_err(serr[2]),
      .break_det(brk[2]), .busy(busy[2]), .frame_cnt(fc2), .err_cnt(ec2));

   function automatic int dataOf(input int i);
      case (i)
         0: return int'(fd0);
         1: return int'(fd1);
         default: return int'(fd2);
      endcase
   endfunction

   function automatic int fcOf(input int i);
      case (i)
         0: return int'(fc0);
         1: return int'(fc1);
         default: return int'(fc2);
      endcase
   endfunction

   function automatic int ecOf(input int i);
      case (i)
         0: return int'(ec0);
         1: return int'(ec1);
         default: return int'(ec2);
      endcase
   endfunction

   // Every comparison goes through here so the counts stay in one place.
   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic pushExp(input int inst, input logic [7:0] data, input logic pe,
                          input logic se, input logic bk, input int fcnt, input int ecnt);
      exp_t e;
      e.inst = inst; e.data = data; e.perr = pe; e.serr = se; e.brk = bk;
      e.fcnt = fcnt; e.ecnt = ecnt;
      expQ.push_back(e);
   endtask

   // One bit period: tick high for one cycle, low for the next.
   task automatic applyStimulus(input int d, input logic b);
      txd[d]  = b;
      tick[d] = 1'b1;
      @(posedge clk); #1;
      tick[d] = 1'b0;
      @(posedge clk); #1;
   endtask

   // par < 0 means no parity bit; nstop selects one or two stop bits.
   task automatic sendFrame(input int d, input logic [7:0] data, input int par,
                            input logic s0, input logic s1, input int nstop);
      applyStimulus(d, 1'b0);
      for (int i = 0; i < 8; i++) applyStimulus(d, data[i]);
      if (par >= 0) applyStimulus(d, par[0]);
      applyStimulus(d, s0);
      if (nstop == 2) applyStimulus(d, s1);
   endtask

   // Scoreboard monitor: compare each presented frame with the queue head.
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (fv[i]) begin
            checkOutput($sformatf("inst%0d_frame_expected", i), int'(expQ.size() > 0), 1);
            if (expQ.size() > 0) begin
               monExp = expQ.pop_front();
               checkOutput($sformatf("inst%0d_source", i), i, monExp.inst);
               checkOutput($sformatf("inst%0d_data", i), dataOf(i), int'(monExp.data));
               checkOutput($sformatf("inst%0d_parity_err", i), int'(perr[i]), int'(monExp.perr));
               checkOutput($sformatf("inst%0d_stop_err", i), int'(serr[i]), int'(monExp.serr));
               checkOutput($sformatf("inst%0d_break_det", i), int'(brk[i]), int'(monExp.brk));
               checkOutput($sformatf("inst%0d_frame_cnt", i), fcOf(i), monExp.fcnt);
               checkOutput($sformatf("inst%0d_err_cnt", i), ecOf(i), monExp.ecnt);
            end
         end
      end
   end

   initial begin
      rstn = 3'b000; tick = 3'b000; txd = 3'b111; en = 3'b111; clr = 3'b000;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_busy_during_reset", int'(busy[0]), 0);
      rstn = 3'b111;
      @(posedge clk); #1;
      checkOutput("rst_frame_valid", int'(fv[0]), 0);
      checkOutput("rst_frame_data", dataOf(0), 0);
      checkOutput("rst_frame_cnt", fcOf(0), 0);
      checkOutput("rst_err_cnt", ecOf(0), 0);
      applyStimulus(0, 1'b1);
      checkOutput("idle_stays_idle", int'(busy[0]), 0);

      $display("[TB] u0: clean, parity error, stop error, break");
      pushExp(0, 8'hA5, 1'b0, 1'b0, 1'b0, 1, 0);
      sendFrame(0, 8'hA5, 0, 1'b1, 1'b1, 1);
      pushExp(0, 8'hA5, 1'b1, 1'b0, 1'b0, 2, 1);
      sendFrame(0, 8'hA5, 1, 1'b1, 1'b1, 1);
      pushExp(0, 8'h3C, 1'b0, 1'b1, 1'b0, 3, 2);
      sendFrame(0, 8'h3C, 0, 1'b0, 1'b1, 1);
      pushExp(0, 8'h00, 1'b0, 1'b0, 1'b1, 4, 3);
      sendFrame(0, 8'h00, 0, 1'b0, 1'b1, 1);
      applyStimulus(0, 1'b1);
      applyStimulus(0, 1'b1);

      $display("[TB] u0: abort with chk_en, then clean frame");
      applyStimulus(0, 1'b0);
      applyStimulus(0, 1'b1);
      applyStimulus(0, 1'b0);
      applyStimulus(0, 1'b0);
      applyStimulus(0, 1'b0);
      checkOutput("abort_busy_before", int'(busy[0]), 1);
      en[0] = 1'b0;
      @(posedge clk); #1;
      checkOutput("abort_busy_after", int'(busy[0]), 0);
      checkOutput("abort_frame_cnt_held", fcOf(0), 4);
      checkOutput("abort_err_cnt_held", ecOf(0), 3);
      en[0] = 1'b1;
      applyStimulus(0, 1'b1);
      applyStimulus(0, 1'b1);
      pushExp(0, 8'h11, 1'b0, 1'b0, 1'b0, 5, 3);
      sendFrame(0, 8'h11, 0, 1'b1, 1'b1, 1);

      $display("[TB] u0: async reset mid-frame");
      applyStimulus(0, 1'b0);
      applyStimulus(0, 1'b1);
      applyStimulus(0, 1'b1);
      checkOutput("midrst_busy_before", int'(busy[0]), 1);
      checkOutput("midrst_data_held", dataOf(0), 8'h11);
      #2;
      rstn[0] = 1'b0;
      #1;
      checkOutput("midrst_busy", int'(busy[0]), 0);
      checkOutput("midrst_frame_data", dataOf(0), 0);
      checkOutput("midrst_frame_cnt", fcOf(0), 0);
      checkOutput("midrst_err_cnt", ecOf(0), 0);
      checkOutput("midrst_frame_valid", int'(fv[0]), 0);
      @(posedge clk); #1;
      txd[0] = 1'b1;
      rstn[0] = 1'b1;
      applyStimulus(0, 1'b1);

      $display("[TB] u1: two stop bits, back-to-back frames");
      applyStimulus(1, 1'b1);
      pushExp(1, 8'h5A, 1'b0, 1'b1, 1'b0, 1, 1);
      pushExp(1, 8'h81, 1'b0, 1'b0, 1'b0, 2, 1);
      sendFrame(1, 8'h5A, -1, 1'b1, 1'b0, 2);
      sendFrame(1, 8'h81, -1, 1'b1, 1'b1, 2);
      applyStimulus(1, 1'b1);

      $display("[TB] u2: counter saturation and clear");
      applyStimulus(2, 1'b1);
      for (int k = 0; k < 5; k++) begin
         pushExp(2, cleanData[k], 1'b0, 1'b0, 1'b0, cleanFc[k], 0);
         sendFrame(2, cleanData[k], -1, 1'b1, 1'b1, 1);
      end
      lastData = 8'h55;
      pushExp(2, lastData, 1'b0, 1'b0, 1'b0, 3, 0);
      applyStimulus(2, 1'b0);
      for (int i = 0; i < 8; i++) applyStimulus(2, lastData[i]);
      txd[2]  = 1'b1;
      tick[2] = 1'b1;
      @(posedge clk); #1;
      tick[2] = 1'b0;
      clr[2]  = 1'b1;
      @(posedge clk); #1;
      clr[2]  = 1'b0;
      checkOutput("clr_frame_cnt", fcOf(2), 0);
      checkOutput("clr_err_cnt", ecOf(2), 0);

      repeat (5) @(posedge clk);
      #1;
      checkOutput("scoreboard_drained", expQ.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_frame_checker.md
Name: uart_frame_checker

Overview:
- Cycle-accurate UART TX line monitor, the parametrised successor to the single-property idle checker.
- Tracks full frames on txd, sampled on bit_tick: start bit, DATA_BITS data bits LSB-first, optional parity bit, STOP_BITS stop bits.
- Reports each decoded byte plus parity, stop and break errors, and keeps saturating frame and error counters.
- Bound beside the UART TX in the testbench; also synthesisable for on-chip debug.

Parameters:
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- PARITY_MODE, 0, parity setting: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, stop bits per frame; legal values 1 or 2.
- CNT_W, 16, width of the frame and error counters.
- ASSERT_EN, 1, when 1, enables concurrent assertions that fire on each error pulse.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- bit_tick  in  1  one-cycle pulse per bit period; txd is sampled only when bit_tick=1.
- txd  in  1  monitored UART TX line.
- chk_en  in  1  checker enable.
- clr_cnt  in  1  synchronous clear of both counters.
- frame_valid  out  1  one-cycle pulse marking a completed frame.
- frame_data  out  DATA_BITS  last decoded data word.
- parity_err  out  1  parity mismatch, qualified by frame_valid.
- stop_err  out  1  a stop bit sampled low, qualified by frame_valid.
- break_det  out  1  break frame detected, qualified by frame_valid.
- busy  out  1  high while a frame is in progress (state is not IDLE).
- frame_cnt  out  CNT_W  completed frames, saturating.
- err_cnt  out  CNT_W  frames with any error, saturating.

Behaviour:
- Reset: rst_n low asynchronously forces state IDLE and zeroes every output, counter, shift register and bit counter. Reset mid-frame discards the partial frame; no frame_valid is produced.
- FSM states: IDLE, DATA, PARITY, STOP. All transitions occur only on cycles with bit_tick=1 and chk_en=1.
- IDLE: sampling txd=0 moves to DATA with bit_cnt=0. Sampling txd=1 stays in IDLE.
- DATA: the sampled bit enters the shift register at position bit_cnt (LSB first).
  - After sample DATA_BITS-1, go to PARITY if PARITY_MODE≠0, otherwise to STOP.
- PARITY: sample the parity bit.
  - Expected bit = XOR of the data bits for even parity; its inverse for odd parity.
  - On mismatch, set a pending parity flag.
- STOP: sample STOP_BITS stop bits; any sample of 0 sets a pending stop flag. After the last stop sample, return to IDLE.
- Completion cycle (the cycle after the last stop sample):
  - frame_valid=1 for exactly one cycle.
  - frame_data is loaded and held until the next frame_valid.
  - parity_err, stop_err and break_det hold their values only in the frame_valid cycle and are 0 otherwise.
- Break: all data bits 0, parity bit 0 if present, and the first stop bit 0.
  - Report break_det=1 with stop_err=0; parity_err is suppressed.
- Back-to-back frames: a start bit may be sampled on the bit_tick immediately after the last stop sample; no idle bit is required.
- Counters:
  - frame_cnt increments on every frame_valid.
  - err_cnt increments when any of parity_err, stop_err or break_det is set.
  - Both saturate at all-ones and update on the same edge that raises frame_valid.
  - clr_cnt=1 zeroes both counters and takes priority over a coincident increment.
- chk_en=0: the next edge forces IDLE and clears the pending flags. An in-flight frame is aborted silently, with no frame_valid and no counting. Counters hold their values.
- bit_tick while frame_valid is high: normal sampling continues; the reporting register is independent of the FSM.
- ASSERT_EN=1: an assertion fires, with message, when frame_valid is high together with any error flag. These assertions are disabled while rst_n is low.

Decomposition:
- uart_pkg holds:
  - the parity_e enum (PAR_NONE, PAR_EVEN, PAR_ODD);
  - the chk_state_e enum (IDLE, DATA, PARITY, STOP);
  - the function expected_parity(data, mode).
- One sub-module, uart_sat_counter (parameter W; ports: inc, clr, count), instantiated twice, once per counter.

Test Plan:
- DATA_BITS=8, even parity, STOP_BITS=1. Send 0xA5 with parity bit 0 and stop bit 1 → frame_valid=1, frame_data=0xA5, no error flags, frame_cnt=1, err_cnt=0.
- Same configuration, 0xA5 with parity bit 1 → parity_err=1, err_cnt=1. Then 0x3C with correct parity and stop bit 0 → stop_err=1, err_cnt=2.
- Same configuration, 11 consecutive low samples → break_det=1, stop_err=0, parity_err=0, err_cnt incremented by 1.
- STOP_BITS=2, PARITY_MODE=0. Send 0x5A with stop bits 1,0 → stop_err=1. Then a back-to-back frame 0x81 with a start bit immediately after → second frame_valid with frame_data=0x81 and no error flags.
- CNT_W=2. Send 5 clean frames → frame_cnt=3 (saturated). Assert clr_cnt in the cycle of the 6th frame_valid → frame_cnt=0 on the following cycle.
- Drop chk_en after 4 data bits, then raise it again → no frame_valid, busy=0 one cycle later. A subsequent clean frame 0x11 is decoded correctly. An async rst_n pulse mid-frame → all outputs 0 immediately.
